shared_mul_sched: RTL
=====================

// Module: shared_mul_sched
// PURPOSE
//   Shares one configurable-precision integer multiplier among NUM_REQ requesters.
//   Round-robin arbitration; valid/ready handshake on both sides; one operation in flight.
//   Operands are truncated to the top cfg_op_bits bits (lower bits zeroed) before the multiply.
//   Sits between the kernel request ports and the single multiply datapath.
// PARAMETERS
//   NUM_REQ            4   number of requesters (>=2)
//   DATA_PATH_BITWIDTH 16  operand/result width
//   MUL_LATENCY        2   cycles from operand latch to product valid (>=1)
//   PREC_W             5   width of cfg_op_bits; equals $clog2(DATA_PATH_BITWIDTH)+1
//   ID_W               2   width of rsp_id; equals $clog2(NUM_REQ)
// PORTS
//   clk          in   1                      clock, rising edge
//   rst          in   1                      reset; asynchronous, active-low
//   req_valid    in   NUM_REQ                per-requester request valid
//   req_ready    out  NUM_REQ                one-hot grant/accept
//   req_a        in   NUM_REQ*DATA_PATH_BITWIDTH  packed operand A; requester i at [i*DPW +: DPW]
//   req_b        in   NUM_REQ*DATA_PATH_BITWIDTH  packed operand B; same packing
//   cfg_op_bits  in   PREC_W                 active precision; sampled at accept
//   rsp_valid    out  1                      result valid
//   rsp_ready    in   1                      result consumer ready
//   rsp_data     out  DATA_PATH_BITWIDTH     product, low DATA_PATH_BITWIDTH bits
//   rsp_id       out  ID_W                   index of the requester that owns rsp_data
//   busy         out  1                      high in every state except IDLE
// BEHAVIOUR
//   Reset (rst=0, async):
//   - state=IDLE, rr_ptr=0, counter=0; operand and result regs = 0.
//   - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//   - Reset mid-operation drops the in-flight op; it produces no response.
//   FSM IDLE -> CALC -> RESP -> IDLE:
//   - IDLE: req_ready = one-hot round-robin pick among req_valid, searching from rr_ptr upward with wrap.
//     - req_ready is combinational from req_valid and is 0 outside IDLE.
//     - Accept on req_valid[g] & req_ready[g]: latch a, b, precision and g.
//       Then rr_ptr <= (g+1) mod NUM_REQ, counter <= MUL_LATENCY-1, next state CALC.
//     - No valid request: stay in IDLE, rr_ptr unchanged.
//   - CALC: counter decrements each cycle. At counter==0, register the product into rsp_data/rsp_id and go to RESP.
//   - RESP: rsp_valid=1. rsp_data and rsp_id stay stable until rsp_ready=1. On rsp_valid & rsp_ready go to IDLE.
//   Timing:
//   - Accept at cycle T gives rsp_valid first high at T+MUL_LATENCY+1.
//   - Earliest next accept is the cycle after the response handshake.
//   - Peak throughput: one op per MUL_LATENCY+2 cycles.
//   Requester rules:
//   - Once req_valid is asserted, hold it and the operands stable until accepted.
//   - Dropping req_valid before grant removes the request; nothing is recorded.
//   Arithmetic:
//   - p = cfg_op_bits, sampled at accept. p=0 or p>DATA_PATH_BITWIDTH is treated as DATA_PATH_BITWIDTH.
//   - Mask keeps bits [DPW-1 : DPW-p] of a and b and zeroes the rest.
//   - rsp_data = (a_masked * b_masked)[DPW-1:0], unsigned; overflow bits are discarded.
//   - A cfg_op_bits change after accept has no effect on the op in flight.
//   Fairness:
//   - A requester holding req_valid is granted within NUM_REQ accepts.
//   - All NUM_REQ valid simultaneously: grants rotate rr_ptr, rr_ptr+1, ... with wrap.
// STRUCTURE
//   Include shared_mul_defs.vh: FSM state encodings (IDLE/CALC/RESP) and the PREC_W/ID_W derivation macros.
//   Sub-module rr_grant (NUM_REQ): inputs req vector and rr_ptr; outputs one-hot grant and encoded index.
//   Purely combinational. The FSM, counter, mask and multiply stay in shared_mul_sched.
// TESTING
//   Reset values:
//   - Stimulus: rst=0 mid-CALC.
//   - Required: next cycle all outputs 0; no rsp_valid after release; next accept uses rr_ptr=0.
//   Single request:
//   - Stimulus: req 1 with a=0x0003, b=0x0005, cfg_op_bits=16, rsp_ready=1.
//   - Required: rsp_data=0x000F, rsp_id=1, rsp_valid at accept+3.
//   Truncation:
//   - Stimulus: a=0x00FF, b=0x0100, cfg_op_bits=8.
//   - Required: masked a=0x0000, so rsp_data=0x0000.
//   - Same operands with cfg_op_bits=0: rsp_data=0xFF00.
//   Round-robin:
//   - Stimulus: all 4 requesters hold valid; rsp_ready=1.
//   - Required: grant order 0,1,2,3,0; exactly one req_ready bit high per accept.
//   Backpressure:
//   - Stimulus: rsp_ready=0 for 5 cycles in RESP, with a=0x1234, b=0x0002.
//   - Required: rsp_data=0x2468 held stable; req_ready stays 0; one accept after release.
//   Overflow:
//   - Stimulus: a=0xFFFF, b=0xFFFF, cfg_op_bits=16.
//   - Required: rsp_data=0x0001.

Source files
------------

// File: rtl/shared_mul_sched_pkg.sv
// Shared definitions for the shared multiplier scheduler.
//   state_t  : FSM state encodings (IDLE/CALC/RESP)
//   prec_w() : width of the precision config port for a given data width
//   id_w()   : width of a requester index for a given requester count
package shared_mul_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int prec_w(input int dpw);
        return $clog2(dpw) + 1;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : highest-priority index; the search runs ptr, ptr+1, ... with wrap
//   gnt  : one-hot grant, all zero when nothing requests
//   idx  : encoded index of the granted bit (0 when nothing requests)
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/shared_mul_sched.sv
// Shares one configurable-precision integer multiplier among NUM_REQ
// requesters with round-robin arbitration and a single op in flight.
//   clk, rst      : clock, asynchronous active-low reset
//   req_valid/ready/a/b : per-requester request side (one-hot ready)
//   cfg_op_bits   : operand precision, sampled at accept
//   rsp_valid/ready/data/id : result side
//   busy          : high whenever an op is in flight or awaiting handshake
module shared_mul_sched
    import shared_mul_sched_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int MUL_LATENCY        = 2,
    parameter int PREC_W             = prec_w(DATA_PATH_BITWIDTH),
    parameter int ID_W               = id_w(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
    input  logic [PREC_W-1:0]               cfg_op_bits,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]   rsp_data,
    output logic [ID_W-1:0]                 rsp_id,
    output logic                            busy
);

    localparam int DPW   = DATA_PATH_BITWIDTH;
    localparam int CNT_W = $clog2(MUL_LATENCY) + 1;

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         own_id;
    logic [CNT_W-1:0]        cnt;
    logic [DPW-1:0]          op_a, op_b;

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gidx;
    logic [DPW-1:0]          sel_a, sel_b;
    logic [PREC_W-1:0]       p_eff;
    logic [DPW-1:0]          mask;
    logic [DPW-1:0]          prod;
    logic                    accept;

    rr_grant #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    // Grant is only offered in IDLE; gated by rst so it is 0 while reset is held.
    assign req_ready = (state == ST_IDLE && rst) ? gnt : '0;
    assign accept    = |req_ready;
    assign busy      = (state != ST_IDLE);

    assign sel_a = req_a[int'(gidx)*DPW +: DPW];
    assign sel_b = req_b[int'(gidx)*DPW +: DPW];

    // p=0 or out-of-range precision means full width; mask keeps the top p bits.
    always_comb begin
        p_eff = cfg_op_bits;
        if (cfg_op_bits == '0 || cfg_op_bits > PREC_W'(DPW))
            p_eff = PREC_W'(DPW);
        mask = {DPW{1'b1}} << (PREC_W'(DPW) - p_eff);
    end

    // Only the low DPW bits of the product are kept.
    assign prod = op_a * op_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            own_id    <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_a   <= sel_a & mask;
                        op_b   <= sel_b & mask;
                        own_id <= gidx;
                        rr_ptr <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
                        cnt    <= CNT_W'(MUL_LATENCY-1);
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cnt == '0) begin
                        rsp_data  <= prod;
                        rsp_id    <= own_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
